// File: rtl/uart_rx.sv
// UART receiver: synchronised rx line, centre sampling, 5..8 data bits, optional parity, 1/2 stop bits.
// Optional build macro UART_RX_GLITCH_FILTER_EN inserts a 3-tap majority filter after the synchroniser.
module uart_rx (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        rx_i,
    output logic        busy_o,
    input  logic        cfg_en_i,
    input  logic [15:0] cfg_div_i,
    input  logic        cfg_parity_en_i,
    input  logic [1:0]  cfg_parity_sel_i,
    input  logic [1:0]  cfg_bits_i,
    input  logic        cfg_stop_bits_i,
    output logic [7:0]  rx_data_o,
    output logic        rx_perr_o,
    output logic        rx_ferr_o,
    output logic        rx_valid_o,
    input  logic        rx_ready_i,
    output logic        rx_ovf_o
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START_BIT  = 3'd1,
        DATA       = 3'd2,
        PARITY     = 3'd3,
        STOP_FIRST = 3'd4,
        STOP_LAST  = 3'd5
    } state_t;

    function automatic logic exp_parity(input logic [7:0] data, input logic [1:0] sel);
        logic p;
        case (sel)
            2'b00:   p = ~^data;
            2'b01:   p = ^data;
            2'b10:   p = 1'b0;
            2'b11:   p = 1'b1;
            default: p = 1'b0;
        endcase
        return p;
    endfunction

    logic        sync1_r, sync2_r;
    logic        line_s, line_prev_r, fall_s;
    state_t      state_r, state_nxt_s;
    logic [15:0] cnt_r;
    logic [2:0]  bit_cnt_r;
    logic [7:0]  data_r;
    logic        perr_r, ferr_r;
    logic        sample_s, last_bit_s, complete_s, ferr_fin_s;
    logic        busy_r, valid_r, ovf_r, out_perr_r, out_ferr_r;
    logic [7:0]  out_data_r;

    // Two-flop synchroniser on the asynchronous serial input
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= rx_i;
            sync2_r <= sync1_r;
        end
    end

`ifdef UART_RX_GLITCH_FILTER_EN
    logic tap1_r, tap2_r;

    // History taps for the majority vote; the vote itself is combinational, so latency is one clock
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tap1_r <= 1'b1;
            tap2_r <= 1'b1;
        end else begin
            tap1_r <= sync2_r;
            tap2_r <= tap1_r;
        end
    end

    assign line_s = (sync2_r & tap1_r) | (sync2_r & tap2_r) | (tap1_r & tap2_r);
`else
    assign line_s = sync2_r;
`endif

    // Previous line value for falling-edge detection
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            line_prev_r <= 1'b1;
        end else begin
            line_prev_r <= line_s;
        end
    end

    assign fall_s     = line_prev_r & ~line_s;
    assign last_bit_s = (bit_cnt_r == ({1'b0, cfg_bits_i} + 3'd4));
    assign ferr_fin_s = ferr_r | ~line_s;

    // Sample strobe and next-state logic
    always_comb begin
        state_nxt_s = state_r;
        sample_s    = 1'b0;
        complete_s  = 1'b0;
        if (state_r == START_BIT) begin
            sample_s = (cnt_r == (cfg_div_i >> 1));
        end else begin
            sample_s = (state_r != IDLE) && (cnt_r == cfg_div_i);
        end
        if (!cfg_en_i) begin
            state_nxt_s = IDLE;
            sample_s    = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (fall_s) state_nxt_s = START_BIT;
                    else        state_nxt_s = IDLE;
                end
                START_BIT: begin
                    if (sample_s) state_nxt_s = line_s ? IDLE : DATA;
                    else          state_nxt_s = START_BIT;
                end
                DATA: begin
                    if (sample_s && last_bit_s) state_nxt_s = cfg_parity_en_i ? PARITY : STOP_FIRST;
                    else                        state_nxt_s = DATA;
                end
                PARITY: begin
                    if (sample_s) state_nxt_s = STOP_FIRST;
                    else          state_nxt_s = PARITY;
                end
                STOP_FIRST: begin
                    if (sample_s && cfg_stop_bits_i) begin
                        state_nxt_s = STOP_LAST;
                    end else if (sample_s) begin
                        state_nxt_s = IDLE;
                        complete_s  = 1'b1;
                    end else begin
                        state_nxt_s = STOP_FIRST;
                    end
                end
                STOP_LAST: begin
                    if (sample_s) begin
                        state_nxt_s = IDLE;
                        complete_s  = 1'b1;
                    end else begin
                        state_nxt_s = STOP_LAST;
                    end
                end
                default: state_nxt_s = IDLE;
            endcase
        end
    end

    // State register; busy is registered from the next state so it mirrors state_r != IDLE
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s != IDLE);
        end
    end

    // Baud counter and frame assembly
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_r     <= 16'd0;
            bit_cnt_r <= 3'd0;
            data_r    <= 8'd0;
            perr_r    <= 1'b0;
            ferr_r    <= 1'b0;
        end else begin
            if (!cfg_en_i || state_r == IDLE || sample_s) cnt_r <= 16'd0;
            else                                          cnt_r <= cnt_r + 16'd1;
            case (state_r)
                IDLE: begin
                    if (fall_s && cfg_en_i) begin
                        bit_cnt_r <= 3'd0;
                        data_r    <= 8'd0;
                        perr_r    <= 1'b0;
                        ferr_r    <= 1'b0;
                    end
                end
                DATA: begin
                    if (sample_s) begin
                        data_r[bit_cnt_r] <= line_s;
                        bit_cnt_r         <= bit_cnt_r + 3'd1;
                    end
                end
                PARITY: begin
                    if (sample_s) perr_r <= (line_s != exp_parity(data_r, cfg_parity_sel_i));
                end
                STOP_FIRST: begin
                    if (sample_s) ferr_r <= ferr_fin_s;
                end
                default: begin
                end
            endcase
        end
    end

    // Output holding register with valid/ready handshake and overrun pulse
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_r    <= 1'b0;
            ovf_r      <= 1'b0;
            out_data_r <= 8'd0;
            out_perr_r <= 1'b0;
            out_ferr_r <= 1'b0;
        end else begin
            ovf_r <= 1'b0;
            if (complete_s && (!valid_r || rx_ready_i)) begin
                valid_r    <= 1'b1;
                out_data_r <= data_r;
                out_perr_r <= perr_r;
                out_ferr_r <= ferr_fin_s;
            end else if (complete_s) begin
                ovf_r <= 1'b1;
            end else if (valid_r && rx_ready_i) begin
                valid_r <= 1'b0;
            end
        end
    end

    assign busy_o     = busy_r;
    assign rx_valid_o = valid_r;
    assign rx_ovf_o   = ovf_r;
    assign rx_data_o  = out_data_r;
    assign rx_perr_o  = out_perr_r;
    assign rx_ferr_o  = out_ferr_r;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus randomized frames against a frame-level model.
module tb_uart_rx;

    logic        clk = 1'b0, rst_n = 1'b0, rx = 1'b1;
    logic        en = 1'b1, par_en = 1'b0, stop2 = 1'b0, ready = 1'b0;
    logic [15:0] div = 16'd15;
    logic [1:0]  sel = 2'd0, bits = 2'd3;
    logic        busy, perr, ferr, valid, ovf;
    logic [7:0]  data;

    int total = 0, bad = 0;
    logic [9:0] got_arr [256];
    int got_n = 0, got_rd = 0, ovf_cnt = 0, busy_cnt = 0;

    uart_rx dut (
        .clk_i(clk), .rst_n_i(rst_n), .rx_i(rx), .busy_o(busy), .cfg_en_i(en),
        .cfg_div_i(div), .cfg_parity_en_i(par_en), .cfg_parity_sel_i(sel),
        .cfg_bits_i(bits), .cfg_stop_bits_i(stop2), .rx_data_o(data), .rx_perr_o(perr),
        .rx_ferr_o(ferr), .rx_valid_o(valid), .rx_ready_i(ready), .rx_ovf_o(ovf)
    );

    always #5 clk = ~clk;

    // Monitor: records accepted frames, overrun cycles and busy cycles just before each rising edge
    always @(negedge clk) begin
        if (valid && ready && got_n < 256) begin
            got_arr[got_n] = {ferr, perr, data};
            got_n++;
        end
        if (ovf) ovf_cnt++;
        if (busy) busy_cnt++;
    end

    // Expected {ferr, perr, data} for a frame, from the framing rules
    function automatic logic [9:0] model(input logic [7:0] d, input int nb, input logic pe,
                                         input logic [1:0] ps, input logic pbit, input logic s1,
                                         input logic two, input logic s2);
        int ones = 0;
        logic [7:0] m = 8'd0;
        logic want;
        for (int i = 0; i < nb; i++) begin
            m[i] = d[i];
            ones += int'(d[i]);
        end
        case (ps)
            2'd0:    want = (ones % 2 == 0);
            2'd1:    want = (ones % 2 == 1);
            2'd2:    want = 1'b0;
            default: want = 1'b1;
        endcase
        return {(!s1 || (two && !s2)), (pe && (pbit != want)), m};
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic put_bit(input logic b);
        rx = b;
        tick(int'(div) + 1);
    endtask

    task automatic send(input logic [7:0] d, input logic pbit, input logic s1, input logic s2);
        put_bit(1'b0);
        for (int i = 0; i < int'(bits) + 5; i++) put_bit(d[i]);
        if (par_en) put_bit(pbit);
        put_bit(s1);
        if (stop2) put_bit(s2);
        rx = 1'b1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Next accepted frame must match exp; bit 10 set in the observed value marks a missing frame
    task automatic check_next(input string tag, input logic [9:0] exp);
        logic [10:0] obs;
        for (int i = 0; i < 400 && got_rd >= got_n; i++) tick(1);
        if (got_rd < got_n) begin
            obs = {1'b0, got_arr[got_rd]};
            got_rd++;
        end else begin
            obs = 11'h7ff;
        end
        check(tag, 32'(obs), 32'({1'b0, exp}));
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 400 && !valid; i++) tick(1);
    endtask

    task automatic frame(input string tag, input logic [7:0] d, input logic pbit,
                         input logic s1, input logic s2);
        logic [9:0] e;
        e = model(d, int'(bits) + 5, par_en, sel, pbit, s1, stop2, s2);
        send(d, pbit, s1, s2);
        check_next(tag, e);
    endtask

    initial begin
        int b0, o0;
        logic [9:0] e;
        logic [7:0] rd;

        // Reset state
        tick(3);
        check("rst_busy", busy, 0); check("rst_data", data, 0); check("rst_perr", perr, 0);
        check("rst_ferr", ferr, 0); check("rst_valid", valid, 0); check("rst_ovf", ovf, 0);
        rst_n = 1'b1;
        tick(5);

        // 8N1 0xA5, ready low: frame held
        send(8'hA5, 1'b0, 1'b1, 1'b1);
        wait_valid();
        check("a5_valid", valid, 1); check("a5_data", data, 8'hA5);
        check("a5_perr", perr, 0); check("a5_ferr", ferr, 0);
        tick(40);
        check("a5_hold_valid", valid, 1); check("a5_hold_data", data, 8'hA5);
        ready = 1'b1;
        check_next("a5_accept", 10'h0A5);
        tick(1);
        check("a5_cleared", valid, 0);

        // 7 bits, odd parity
        bits = 2'd2; par_en = 1'b1; sel = 2'd0;
        frame("par_ok", 8'h55, 1'b1, 1'b1, 1'b1);
        frame("par_bad", 8'h55, 1'b0, 1'b1, 1'b1);
        check("par_bad_model", 32'(model(8'h55, 7, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1)), 32'h155);

        // 8N2 framing
        bits = 2'd3; par_en = 1'b0; stop2 = 1'b1;
        frame("ferr_stop2", 8'hC3, 1'b0, 1'b1, 1'b0);
        tick(20);
        stop2 = 1'b0;
        frame("ferr_none", 8'h96, 1'b0, 1'b1, 1'b1);

        // Back-to-back with ready low: overrun
        ready = 1'b0;
        o0 = ovf_cnt;
        send(8'h11, 1'b0, 1'b1, 1'b1);
        send(8'h22, 1'b0, 1'b1, 1'b1);
        tick(3);
        check("ovf_data_kept", data, 8'h11); check("ovf_valid", valid, 1);
        check("ovf_pulses", ovf_cnt - o0, 1);
        ready = 1'b1;
        check_next("ovf_held", 10'h011);
        tick(10);
        check("ovf_dropped", got_n - got_rd, 0);
        send(8'h11, 1'b0, 1'b1, 1'b1);
        send(8'h22, 1'b0, 1'b1, 1'b1);
        check_next("b2b_first", 10'h011);
        check_next("b2b_second", 10'h022);

        // False start: 3-clock low pulse
        tick(20);
        b0 = busy_cnt;
        rx = 1'b0; tick(3); rx = 1'b1;
        tick(40);
        check("fs_started", busy_cnt > b0, 1); check("fs_idle", busy, 0);
        check("fs_novalid", valid, 0); check("fs_nodeliver", got_n - got_rd, 0);

        // 1-clock glitch
        b0 = busy_cnt;
        rx = 1'b0; tick(1); rx = 1'b1;
        tick(40);
`ifdef UART_RX_GLITCH_FILTER_EN
        check("glitch_rejected", busy_cnt - b0, 0);
`else
        check("glitch_seen", busy_cnt > b0, 1);
`endif
        check("glitch_novalid", valid, 0);

        // Enable dropped mid-DATA
        put_bit(1'b0); put_bit(1'b0); put_bit(1'b1); put_bit(1'b0);
        check("en_busy_before", busy, 1);
        en = 1'b0; tick(2);
        check("en_busy_drop", busy, 0);
        rx = 1'b1; tick(60);
        check("en_no_partial", got_n - got_rd, 0); check("en_novalid", valid, 0);
        en = 1'b1; tick(5);
        frame("en_3c", 8'h3C, 1'b0, 1'b1, 1'b1);
        tick(10);
        check("en_only_one", got_n - got_rd, 0);

        // Randomized frames
        for (int k = 0; k < 24; k++) begin
            logic [7:0] d;
            logic pb, s1, s2;
            div    = 16'($urandom_range(9, 24));
            bits   = 2'($urandom_range(0, 3));
            par_en = 1'($urandom_range(0, 1));
            sel    = 2'($urandom_range(0, 3));
            stop2  = 1'($urandom_range(0, 1));
            d      = 8'($urandom);
            pb     = 1'($urandom_range(0, 1));
            s1     = ($urandom_range(0, 7) != 0);
            s2     = ($urandom_range(0, 7) != 0);
            frame($sformatf("rnd%0d", k), d, pb, s1, s2);
            tick(2 * (int'(div) + 1));
        end

        // Asynchronous reset mid-frame with a frame held
        div = 16'd15; bits = 2'd3; par_en = 1'b0; stop2 = 1'b0;
        ready = 1'b0;
        send(8'h5A, 1'b0, 1'b1, 1'b1);
        wait_valid();
        rd = data;
        check("mr_held", {valid, rd}, 9'h15A);
        put_bit(1'b0); put_bit(1'b1); put_bit(1'b0);
        check("mr_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mr_busy0", busy, 0); check("mr_valid0", valid, 0); check("mr_data0", data, 0);
        check("mr_perr0", perr, 0); check("mr_ferr0", ferr, 0); check("mr_ovf0", ovf, 0);
        rx = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
